// File: rtl/leds_pkg.sv
// Shared types and constants for the LED PWM driver.
package leds_pkg;
  localparam int unsigned PWM_WIDTH = 8;
  localparam int unsigned NUM_LEDS  = 4;

  typedef logic [PWM_WIDTH-1:0] brightness_t;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_state_t;
endpackage

// File: rtl/leds_driver_if.sv
// Control/pin bundle between the LED bus-interface stage (master) and the PWM driver (slave).
interface leds_driver_if;
  import leds_pkg::*;

  logic        ctrl_en;
  logic        ctrl_led0;
  logic        ctrl_led1;
  logic        ctrl_led2;
  logic        ctrl_led3;
  brightness_t brightness;
  logic        blink_en;
  logic        led0;
  logic        led1;
  logic        led2;
  logic        led3;
  logic        period_start;

  modport master (
    output ctrl_en, ctrl_led0, ctrl_led1, ctrl_led2, ctrl_led3, brightness, blink_en,
    input  led0, led1, led2, led3, period_start
  );

  modport slave (
    input  ctrl_en, ctrl_led0, ctrl_led1, ctrl_led2, ctrl_led3, brightness, blink_en,
    output led0, led1, led2, led3, period_start
  );
endinterface

// File: rtl/leds_driver_tick_divider.sv
// Prescaler: counts 0..DIV-1 and flags the cycle holding DIV-1; clr holds it at 0.
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = !clr && (cnt_q == LAST);
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/leds_driver.sv
// Four-channel PWM LED driver with period-aligned duty latching and optional blinking.
// Blink FSM is built only when LEDS_BLINK_EN is defined; otherwise the phase is always ON.
module leds_driver
  import leds_pkg::*;
#(
  parameter int unsigned PRESCALE      = 4,
  parameter int unsigned BLINK_PERIODS = 64,
  parameter int unsigned ACTIVE_LOW    = 0
) (
  input  logic          clk,
  input  logic          rst,
  leds_driver_if.slave  bus
);
  localparam logic DARK = (ACTIVE_LOW != 0);

  logic                tick;
  logic                presc_clr;
  brightness_t         pwm_cnt_q, pwm_cnt_d;
  brightness_t         duty_q, duty_d;
  logic                first_q, first_d;
  logic                period_start_q, period_start_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [NUM_LEDS-1:0] ctrl_led;
  logic                boundary, wrap, phase_on;

  assign presc_clr = !bus.ctrl_en;
  assign ctrl_led  = {bus.ctrl_led3, bus.ctrl_led2, bus.ctrl_led1, bus.ctrl_led0};

  tick_divider #(.DIV(PRESCALE)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .tick (tick)
  );

  // first_q marks "enabled but no tick yet": the first tick opens a period
  // at step 0 instead of advancing the counter, so that period is full length.
  always_comb begin
    boundary       = tick && (first_q || (pwm_cnt_q == '1));
    wrap           = tick && !first_q && (pwm_cnt_q == '1);
    pwm_cnt_d      = pwm_cnt_q;
    first_d        = first_q;
    duty_d         = duty_q;
    period_start_d = boundary;
    if (!bus.ctrl_en) begin
      pwm_cnt_d = '0;
      first_d   = 1'b1;
    end else if (tick) begin
      first_d = 1'b0;
      if (!first_q) pwm_cnt_d = pwm_cnt_q + 1'b1;
    end
    if (boundary) duty_d = bus.brightness;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      led_d[i] = DARK ^ (bus.ctrl_en && ctrl_led[i] && !first_q &&
                         (pwm_cnt_q < duty_q) && phase_on);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q      <= '0;
      duty_q         <= '0;
      first_q        <= 1'b1;
      period_start_q <= 1'b0;
      led_q          <= {NUM_LEDS{DARK}};
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      duty_q         <= duty_d;
      first_q        <= first_d;
      period_start_q <= period_start_d;
      led_q          <= led_d;
    end
  end

`ifdef LEDS_BLINK_EN
  localparam int unsigned BCW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_PERIODS - 1);

  blink_state_t   blink_state_q;
  logic [BCW-1:0] blink_cnt_q;

  // Phase advances only on true period wraps, never on the opening tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_state_q <= BLINK_ON;
      blink_cnt_q   <= '0;
    end else if (!bus.ctrl_en || !bus.blink_en) begin
      blink_state_q <= BLINK_ON;
      blink_cnt_q   <= '0;
    end else if (wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        case (blink_state_q)
          BLINK_ON:  blink_state_q <= BLINK_OFF;
          BLINK_OFF: blink_state_q <= BLINK_ON;
          default:   blink_state_q <= BLINK_ON;
        endcase
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign phase_on = (blink_state_q == BLINK_ON);
`else
  logic unused_blink;
  assign unused_blink = bus.blink_en | wrap | (BLINK_PERIODS == 0);
  assign phase_on     = 1'b1;
`endif

  assign bus.led0         = led_q[0];
  assign bus.led1         = led_q[1];
  assign bus.led2         = led_q[2];
  assign bus.led3         = led_q[3];
  assign bus.period_start = period_start_q;
endmodule
